cursor_readout: RTL and testbench

CURSOR_READOUT -- requirements
Module: cursor_readout

---
 rtl/cursor_readout.sv | 212 +++++++++++++++++++++
 tb/tb_cursor_readout.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cursor_readout.sv
// cursor_readout
//   Measures the distance between two cursors on request and shows the scaled
//   result as six active-low 7-segment digits.
//   Mode 0: value = |Y1 - Y2| << shiftDown1
//   Mode 1: value = |X1 - X2| * (sampleAdjust1 + 1)
//   The value is saturated to 999999 and converted to BCD one bit per cycle
//   (double dabble). Leading zeros are blanked.
//
// Ports
//   clock, reset                 sole clock; asynchronous active-high reset
//   sampleTick                   one-cycle measurement request (ignored while busy)
//   modeSelect                   0 = Y-cursor delta, 1 = X-cursor delta
//   cursorX1/X2/Y1/Y2 [10:0]     cursor pixel positions
//   cursorX_EN, cursorY_EN       cursor enables; disabled cursor blanks the display
//   shiftDown1 [3:0]             vertical scale exponent
//   sampleAdjust1 [5:0]          horizontal scale factor minus one
//   hex0..hex5 [6:0]             segments g..a, active low, hex0 least significant
//   busy                         high while a measurement is in progress
//   valid                        one-cycle pulse when hex outputs update
module cursor_readout (
  input  logic        clock,
  input  logic        reset,
  input  logic        sampleTick,
  input  logic        modeSelect,
  input  logic [10:0] cursorX1,
  input  logic [10:0] cursorX2,
  input  logic [10:0] cursorY1,
  input  logic [10:0] cursorY2,
  input  logic        cursorX_EN,
  input  logic        cursorY_EN,
  input  logic [3:0]  shiftDown1,
  input  logic [5:0]  sampleAdjust1,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, SCALE, CONVERT, LOAD} state_t;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [25:0] VALUE_MAX  = 26'd999999;
  localparam logic [4:0]  LAST_BIT   = 5'd19;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              en_q, en_d;
  logic [10:0]       pos_a_q, pos_a_d;
  logic [10:0]       pos_b_q, pos_b_d;
  logic [3:0]        shift_q, shift_d;
  logic [5:0]        adj_q, adj_d;
  logic [19:0]       bin_q, bin_d;
  logic [23:0]       bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [5:0][6:0]   hex_q, hex_d;
  logic              valid_q, valid_d;

  // Scaling datapath, evaluated from the latched operands.
  logic [10:0]       delta;
  logic [25:0]       value;
  logic [19:0]       value_sat;
  logic [23:0]       bcd_adj;
  logic [5:0][6:0]   digit_seg;
  logic [5:0][6:0]   disp;
  logic [5:0]        digit_nz;
  logic [5:0]        digit_show;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    delta = (pos_a_q >= pos_b_q) ? (pos_a_q - pos_b_q) : (pos_b_q - pos_a_q);
    // 26 bits covers 2047 << 15, the largest possible product or shift.
    if (mode_q)
      value = {15'd0, delta} * {19'd0, ({1'b0, adj_q} + 7'd1)};
    else
      value = {15'd0, delta} << shift_q;
    value_sat = (value > VALUE_MAX) ? VALUE_MAX[19:0] : value[19:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      // Add-3 correction applied before each shift of the double dabble.
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                             : bcd_q[4*gi +: 4];
      assign digit_seg[gi] = seg7(bcd_q[4*gi +: 4]);
      assign digit_nz[gi]  = (bcd_q[4*gi +: 4] != 4'd0);
      // A digit is shown if it or any more significant digit is non-zero;
      // the units digit is always shown so zero reads "0".
      if (gi == 0) begin : g_units
        assign digit_show[gi] = 1'b1;
      end else if (gi == 5) begin : g_top
        assign digit_show[gi] = digit_nz[gi];
      end else begin : g_mid
        assign digit_show[gi] = digit_nz[gi] | digit_show[gi+1];
      end
      assign disp[gi] = (en_q && digit_show[gi]) ? digit_seg[gi] : SEG_BLANK;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    en_d    = en_q;
    pos_a_d = pos_a_q;
    pos_b_d = pos_b_q;
    shift_d = shift_q;
    adj_d   = adj_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (sampleTick) begin
          mode_d = modeSelect;
          if (modeSelect) begin
            en_d    = cursorX_EN;
            pos_a_d = cursorX1;
            pos_b_d = cursorX2;
            adj_d   = sampleAdjust1;
          end else begin
            en_d    = cursorY_EN;
            pos_a_d = cursorY1;
            pos_b_d = cursorY2;
            shift_d = shiftDown1;
          end
          state_d = SCALE;
        end
      end
      SCALE: begin
        bin_d   = value_sat;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        bcd_d = {bcd_adj[22:0], bin_q[19]};
        bin_d = {bin_q[18:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_BIT)
          state_d = LOAD;
      end
      LOAD: begin
        hex_d   = disp;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      pos_a_q <= '0;
      pos_b_q <= '0;
      shift_q <= '0;
      adj_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= {6{SEG_BLANK}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      pos_a_q <= pos_a_d;
      pos_b_q <= pos_b_d;
      shift_q <= shift_d;
      adj_q   <= adj_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = valid_q;
  assign hex0  = hex_q[0];
  assign hex1  = hex_q[1];
  assign hex2  = hex_q[2];
  assign hex3  = hex_q[3];
  assign hex4  = hex_q[4];
  assign hex5  = hex_q[5];

endmodule

// File: tb/tb_cursor_readout.sv
// Directed bench for cursor_readout: reset state, both modes, saturation,
// blanking, ignored ticks while busy, input changes after latch and abort.
module tb_cursor_readout;

  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sampleTick = 1'b0;
  logic        modeSelect = 1'b0;
  logic [10:0] cursorX1 = '0, cursorX2 = '0, cursorY1 = '0, cursorY2 = '0;
  logic        cursorX_EN = 1'b0, cursorY_EN = 1'b0;
  logic [3:0]  shiftDown1 = '0;
  logic [5:0]  sampleAdjust1 = '0;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy, valid;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cursor_readout dut (
    .clock(clock), .reset(reset), .sampleTick(sampleTick), .modeSelect(modeSelect),
    .cursorX1(cursorX1), .cursorX2(cursorX2), .cursorY1(cursorY1), .cursorY2(cursorY2),
    .cursorX_EN(cursorX_EN), .cursorY_EN(cursorY_EN),
    .shiftDown1(shiftDown1), .sampleAdjust1(sampleAdjust1),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .valid(valid)
  );

  function automatic logic [41:0] hexes();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setup_y(input int y1, input int y2, input int sh, input bit en);
    modeSelect = 1'b0; cursorY1 = 11'(y1); cursorY2 = 11'(y2);
    shiftDown1 = 4'(sh); cursorY_EN = en;
  endtask

  task automatic setup_x(input int x1, input int x2, input int adj, input bit en);
    modeSelect = 1'b1; cursorX1 = 11'(x1); cursorX2 = 11'(x2);
    sampleAdjust1 = 6'(adj); cursorX_EN = en;
  endtask

  // Ticks at edge k, then follows edges k+1.. checking valid every cycle,
  // busy mid-run and after return, and the display at edge k+22.
  task automatic run_meas(input string tag, input logic [41:0] exp_hex,
                          input bit disturb, input bit second_tick);
    int last;
    last = second_tick ? 50 : 24;
    @(negedge clock); sampleTick = 1'b1;
    @(posedge clock); #1; sampleTick = 1'b0;
    for (int n = 1; n <= last; n++) begin
      if (disturb && n == 1) begin
        modeSelect = ~modeSelect;
        cursorX1 = cursorX1 + 11'd7;  cursorX_EN = ~cursorX_EN;
        cursorY1 = cursorY1 + 11'd5;  cursorY_EN = ~cursorY_EN;
        shiftDown1 = shiftDown1 + 4'd1; sampleAdjust1 = sampleAdjust1 + 6'd3;
      end
      if (second_tick && n == 4) sampleTick = 1'b1;
      if (second_tick && n == 5) sampleTick = 1'b0;
      @(posedge clock); #1;
      check($sformatf("%s valid@k+%0d", tag, n), {41'd0, valid}, {41'd0, (n == 22)});
      if (n == 1 || n == 21)
        check($sformatf("%s busy@k+%0d", tag, n), {41'd0, busy}, 42'd1);
      if (n == 24)
        check($sformatf("%s idle@k+%0d", tag, n), {41'd0, busy}, 42'd0);
      if (n == 22)
        check($sformatf("%s hex", tag), hexes(), exp_hex);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    check("reset hex", hexes(), {6{B}});
    check("reset busy", {41'd0, busy}, 42'd0);
    check("reset valid", {41'd0, valid}, 42'd0);
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("post-reset hex", hexes(), {6{B}});
    check("post-reset busy/valid", {40'd0, busy, valid}, 42'd0);

    setup_y(60, 120, 3, 1'b1);
    run_meas("y480", {B, B, B, S4, S8, S0}, 1'b0, 1'b0);

    setup_x(90, 32, 0, 1'b1);
    run_meas("x58 disturbed", {B, B, B, B, S5, S8}, 1'b1, 1'b0);

    setup_x(90, 32, 9, 1'b1);
    run_meas("x580", {B, B, B, S5, S8, S0}, 1'b0, 1'b0);

    setup_y(120, 60, 0, 1'b1);
    run_meas("y60 swapped", {B, B, B, B, S6, S0}, 1'b0, 1'b0);

    setup_y(0, 2047, 15, 1'b1);
    run_meas("saturate", {6{S9}}, 1'b0, 1'b0);

    setup_y(500, 500, 2, 1'b1);
    run_meas("equal", {B, B, B, B, B, S0}, 1'b0, 1'b0);

    setup_y(60, 120, 3, 1'b0);
    run_meas("y disabled", {6{B}}, 1'b0, 1'b0);

    setup_y(60, 120, 3, 1'b1);
    run_meas("second tick", {B, B, B, S4, S8, S0}, 1'b0, 1'b1);

    // Abort mid-conversion: display currently shows "480".
    setup_y(0, 2047, 15, 1'b1);
    @(negedge clock); sampleTick = 1'b1;
    @(posedge clock); #1; sampleTick = 1'b0;
    repeat (10) @(posedge clock);
    #1; reset = 1'b1;
    #1;
    check("abort busy", {41'd0, busy}, 42'd0);
    check("abort valid", {41'd0, valid}, 42'd0);
    check("abort hex", hexes(), {6{B}});
    @(negedge clock); reset = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
        @(posedge clock); #1;
        if (valid !== 1'b0) pulses++;
      end
      check("abort no valid", 42'(pulses), 42'd0);
      check("abort hex held", hexes(), {6{B}});
    end

    setup_x(90, 32, 0, 1'b1);
    run_meas("after abort", {B, B, B, B, S5, S8}, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
